// File: rtl/muldiv_alu_if.sv
// Request/response bundle of the execute-stage ALU: operation request with
// valid/ready on the way in, registered result with valid/ready on the way out.
interface muldiv_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] data_one;
    logic [XLEN-1:0] data_two;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    modport master (
        output in_valid, alu_op, data_one, data_two, out_ready,
        input  in_ready, out_valid, alu_result, zero
    );

    modport slave (
        input  in_valid, alu_op, data_one, data_two, out_ready,
        output in_ready, out_valid, alu_result, zero
    );
endinterface

// File: rtl/muldiv_alu.sv
// Handshaked execute unit: single-cycle base/branch ops plus iterative RV32M
// shift-add multiply and restoring divide, with synchronous flush.
module muldiv_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    muldiv_alu_if.slave  bus
);
    localparam int CNT_W = SHW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi, lo, mcand, a_q;
    logic [2:0]        m_op;
    logic              neg_q, rem_neg_q, bzero_q;
    logic              out_valid_q, zero_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   a, b, base_res, mag_a, mag_b;
    logic [SHW-1:0]    sh;
    logic              lt_s, lt_u, eq, is_mop, sgn_a, sgn_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;

    assign a  = bus.data_one;
    assign b  = bus.data_two;
    assign sh = b[SHW-1:0];
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;
    assign eq   = a == b;

    always_comb begin
        base_res = '0;
        unique case (bus.alu_op)
            5'h00: base_res = a + b;
            5'h01: base_res = a - b;
            5'h02: base_res = a << sh;
            5'h03: base_res = {{(XLEN-1){1'b0}}, lt_s};
            5'h04: base_res = {{(XLEN-1){1'b0}}, lt_u};
            5'h05: base_res = a ^ b;
            5'h06: base_res = $unsigned($signed(a) >>> sh);
            5'h07: base_res = a >> sh;
            5'h08: base_res = a | b;
            5'h09: base_res = a & b;
            5'h0A: base_res = {{(XLEN-1){1'b0}}, !eq};
            5'h0B: base_res = {{(XLEN-1){1'b0}}, eq};
            5'h0C: base_res = {{(XLEN-1){1'b0}}, !lt_s};
            5'h0D: base_res = {{(XLEN-1){1'b0}}, lt_s};
            5'h0E: base_res = {{(XLEN-1){1'b0}}, !lt_u};
            5'h0F: base_res = {{(XLEN-1){1'b0}}, lt_u};
            default: base_res = '0;
        endcase
    end

    // M-op signedness: MULHSU treats B as unsigned; the *U variants are fully unsigned.
    assign is_mop = bus.alu_op[4] && !bus.alu_op[3];
    assign sgn_a  = a[XLEN-1] && !(bus.alu_op[2:0] inside {3'd3, 3'd5, 3'd7});
    assign sgn_b  = b[XLEN-1] && (bus.alu_op[2:0] inside {3'd0, 3'd1, 3'd4, 3'd6});
    assign mag_a  = sgn_a ? -a : a;
    assign mag_b  = sgn_b ? -b : b;

    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mcand};

    assign prod_fix = neg_q ? -{hi, lo} : {hi, lo};
    assign q_fix    = neg_q ? -lo : lo;
    assign r_fix    = rem_neg_q ? -hi : hi;

    always_comb begin
        fix_res = '0;
        unique case (m_op)
            3'd0:             fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = bzero_q ? '1 : q_fix;
            default:          fix_res = bzero_q ? a_q : r_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            mcand       <= '0;
            a_q         <= '0;
            m_op        <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            bzero_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else if (flush) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (bus.in_valid) begin
                    if (is_mop) begin
                        m_op      <= bus.alu_op[2:0];
                        neg_q     <= sgn_a ^ sgn_b;
                        rem_neg_q <= sgn_a;
                        bzero_q   <= (b == '0);
                        a_q       <= a;
                        hi        <= '0;
                        // Multiply shifts the multiplier out of lo; divide shifts the dividend.
                        lo        <= bus.alu_op[2] ? mag_a : mag_b;
                        mcand     <= bus.alu_op[2] ? mag_b : mag_a;
                        cnt       <= '0;
                        state     <= bus.alu_op[2] ? ST_DIV : ST_MUL;
                    end else begin
                        result_q    <= base_res;
                        zero_q      <= (base_res == '0);
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt == CNT_W'(XLEN)) begin
                        result_q    <= fix_res;
                        zero_q      <= (fix_res == '0);
                        out_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (state == ST_MUL) begin
                            {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
                        end else if (!div_diff[XLEN]) begin
                            hi <= div_diff[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end
                end
                ST_DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = result_q;
    assign bus.zero       = zero_q;
endmodule

// File: tb/tb_muldiv_alu.sv
// Bench for muldiv_alu: directed vector table, random ops against an arithmetic
// reference model, and hand-written back-pressure/flush/reset sequences.
module tb_muldiv_alu;
    localparam int XLEN  = 32;
    localparam int M_LAT = XLEN + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    muldiv_alu_if #(.XLEN(XLEN)) bus ();
    muldiv_alu #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural definitions.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0] pu;
        logic [4:0] s;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        ub = {32'b0, b};
        s  = b[4:0];
        case (op)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a << s;
            5'h03: return (sa < sb) ? 32'd1 : 32'd0;
            5'h04: return (a < b) ? 32'd1 : 32'd0;
            5'h05: return a ^ b;
            5'h06: begin p = sa >>> s; return p[31:0]; end
            5'h07: return a >> s;
            5'h08: return a | b;
            5'h09: return a & b;
            5'h0A: return (a == b) ? 32'd0 : 32'd1;
            5'h0B: return (a != b) ? 32'd0 : 32'd1;
            5'h0C: return (sa < sb) ? 32'd0 : 32'd1;
            5'h0D: return (sa >= sb) ? 32'd0 : 32'd1;
            5'h0E: return (a < b) ? 32'd0 : 32'd1;
            5'h0F: return (a >= b) ? 32'd0 : 32'd1;
            5'h10: begin p = sa * sb; return p[31:0]; end
            5'h11: begin p = sa * sb; return p[63:32]; end
            5'h12: begin p = sa * ub; return p[63:32]; end
            5'h13: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            5'h14: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            5'h17: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
        chk("in_ready_before_issue", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.data_one = a;
        bus.data_two = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.alu_op   = 5'($urandom);
        bus.data_one = $urandom;
        bus.data_two = $urandom;
    endtask

    // lat = number of edges from accept until the edge that sees out_valid.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        start(op, a, b);
        chk("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("in_ready_after_take", {31'b0, bus.in_ready}, 32'd1);
        chk("out_valid_after_take", {31'b0, bus.out_valid}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic z, input int exp_lat);
        int lat;
        issue(op, a, b, lat);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, bus.alu_result, res);
        chk({name, "_zero"}, {31'b0, bus.zero}, {31'b0, z});
        take();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, ones;
        logic [4:0] op;
        logic [31:0] a, b, r;

        bus.in_valid = 1'b0; bus.alu_op = '0; bus.data_one = '0; bus.data_two = '0; bus.out_ready = 1'b0;

        vecs.push_back('{5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1});
        vecs.push_back('{5'h06, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1});
        vecs.push_back('{5'h01, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1});
        vecs.push_back('{5'h02, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 1});
        vecs.push_back('{5'h03, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1});
        vecs.push_back('{5'h04, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1});
        vecs.push_back('{5'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1});
        vecs.push_back('{5'h07, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1});
        vecs.push_back('{5'h08, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1});
        vecs.push_back('{5'h09, 32'h0000_00F0, 32'h0000_000F, 32'd0,         1'b1, 1});
        vecs.push_back('{5'h0A, 32'd5,         32'd5,         32'd0,         1'b1, 1});
        vecs.push_back('{5'h0B, 32'd5,         32'd5,         32'd1,         1'b0, 1});
        vecs.push_back('{5'h0C, 32'hFFFF_FFFF, 32'd0,         32'd0,         1'b1, 1});
        vecs.push_back('{5'h0D, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 1});
        vecs.push_back('{5'h0E, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1, 1});
        vecs.push_back('{5'h0F, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1});
        vecs.push_back('{5'h1F, 32'd1234,      32'd5678,      32'd0,         1'b1, 1});
        vecs.push_back('{5'h10, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, M_LAT});
        vecs.push_back('{5'h11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, M_LAT});
        vecs.push_back('{5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, M_LAT});
        vecs.push_back('{5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, M_LAT});
        vecs.push_back('{5'h13, 32'd0,         32'd5,         32'd0,         1'b1, M_LAT});
        vecs.push_back('{5'h14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, M_LAT});
        vecs.push_back('{5'h16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, M_LAT});
        vecs.push_back('{5'h14, 32'd12345,     32'd0,         32'hFFFF_FFFF, 1'b0, M_LAT});
        vecs.push_back('{5'h14, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b0, M_LAT});
        vecs.push_back('{5'h16, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0, M_LAT});
        vecs.push_back('{5'h17, 32'd9,         32'd0,         32'd9,         1'b0, M_LAT});
        vecs.push_back('{5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, M_LAT});
        vecs.push_back('{5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, M_LAT});
        vecs.push_back('{5'h15, 32'd100,       32'd7,         32'd14,        1'b0, M_LAT});
        vecs.push_back('{5'h17, 32'd100,       32'd7,         32'd2,         1'b0, M_LAT});

        // Reset state while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_result", bus.alu_result, 32'd0);
        chk("reset_zero", {31'b0, bus.zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op($sformatf("vec%0d_op%02h", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].z, vecs[i].lat);

        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom_range(0, 31));
            a = pick();
            b = pick();
            r = model(op, a, b);
            run_op($sformatf("rand%0d_op%02h_%h_%h", i, op, a, b), op, a, b, r, r == 0,
                   (op[4] && !op[3]) ? M_LAT : 1);
        end

        // Back-pressure: result held, no new acceptance until handshake.
        issue(5'h00, 32'h1234_5678, 32'h1111_1111, lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("hold_result", bus.alu_result, 32'h2345_6789);
            chk("hold_zero", {31'b0, bus.zero}, 32'd0);
            chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        take();

        // Flush 10 cycles into a DIV while a new request is offered.
        start(5'h14, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_op = 5'h00; bus.data_one = 32'd1; bus.data_two = 32'd1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) ones++;
        end
        chk("flush_no_result", 32'(ones), 32'd0);

        // Flush while a result is waiting drops it.
        issue(5'h00, 32'd4, 32'd4, lat);
        chk("flush_done_pre", {31'b0, bus.out_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_done_in_ready", {31'b0, bus.in_ready}, 32'd1);
        run_op("after_flush_sub", 5'h01, 32'd9, 32'd4, 32'd5, 1'b0, 1);

        // Asynchronous reset mid-MUL, applied away from any clock edge.
        start(5'h10, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("async_rst_result", bus.alu_result, 32'd0);
        chk("async_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("async_rst_zero", {31'b0, bus.zero}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) ones++;
        end
        chk("rst_no_stale_result", 32'(ones), 32'd0);
        run_op("post_reset_add", 5'h00, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_alu.md
# muldiv_alu

Parametrised, handshaked execution unit for the RISC-V core. It replaces the single-cycle combinational ALU in the execute stage. It keeps the base integer/branch-compare operation set, adds unsigned branch compares, and adds the full RV32M multiply/divide set, which runs as an iterative shift-add / restoring-division datapath. Operands are captured on acceptance. Results are registered and held under valid/ready back-pressure, and a synchronous flush aborts in-flight work on pipeline redirects.

## Interface
- XLEN, 32, datapath width; power of two, ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived; do not override)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any accepted or in-flight operation
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; equals (state == IDLE)
- alu_op  in  5  operation code (see Operation)
- data_one  in  XLEN  operand A
- data_two  in  XLEN  operand B
- out_valid  out  1  alu_result/zero valid
- out_ready  in  1  consumer takes the result
- alu_result  out  XLEN  registered result
- zero  out  1  registered (alu_result == 0)

One clock; reset is asynchronous and active-low.

## Operation
- **Accept.** An operation is accepted on an edge where in_valid && in_ready && !flush. alu_op, data_one and data_two are latched on that edge; input changes afterwards are ignored.
- **Base ops (0x00–0x0F).** Shift amount is data_two[SHW-1:0].
  - 0x00 ADD, 0x01 SUB, 0x02 SLL, 0x03 SLT (signed), 0x04 SLTU, 0x05 XOR, 0x06 SRA, 0x07 SRL, 0x08 OR, 0x09 AND.
  - SLT/SLTU produce 0 or 1, zero-extended.
- **Branch ops.** Result is 0 when the branch is taken, 1 otherwise, so zero = taken.
  - 0x0A BEQ: result = (A != B).
  - 0x0B BNE: result = (A == B).
  - 0x0C BLT: result = !(A <s B).
  - 0x0D BGE: result = !(A >=s B).
  - 0x0E BLTU: result = !(A <u B).
  - 0x0F BGEU: result = !(A >=u B).
- **M ops (0x10–0x17).** 0x10 MUL (low XLEN), 0x11 MULH (s×s high), 0x12 MULHSU (s×u high), 0x13 MULHU (u×u high), 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
- **Multiply.** Operands are converted to magnitudes per signedness. XLEN shift-add iterations build a 2·XLEN product, then one fixup cycle negates it if the signs differ and selects the high or low half.
- **Divide.** Magnitudes, XLEN restoring iterations, then one fixup cycle.
  - Quotient sign = sign(A) ^ sign(B).
  - Remainder sign = sign(A).
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = A.
  - Signed overflow (A = 1<<(XLEN-1), B = −1): quotient = A, remainder = 0.
  - These special cases follow the normal iterative latency; there is no fast path.
- **Undefined codes (0x18–0x1F).** result = 0, zero = 1, base-op latency.
- **State machine.** IDLE, MUL, DIV, DONE.
  - IDLE → DONE on accept of a base/undefined op.
  - IDLE → MUL / DIV on accept of an M op.
  - MUL/DIV: an iteration counter counts XLEN steps, plus one fixup step, then → DONE.
  - DONE: out_valid = 1. On out_valid && out_ready → IDLE.
  - flush in any state → IDLE on the next edge. The result is discarded and out_valid drops.
  - flush has priority over acceptance and over an out_ready handshake in the same cycle.

## Timing
- **Latency**, for acceptance on edge N:
  - Base and undefined ops: out_valid high from edge N+1.
  - M ops: out_valid high from edge N+XLEN+2.
- **Hold.** alu_result and zero stay stable while out_valid && !out_ready.
- **No overlap.** in_ready is low from edge N until the edge after the result handshake. Base-op throughput is one operation every 2 cycles.
- **in_ready is combinational from state only**, with no path from in_valid.
- **Reset values.** While rst_n = 0: state = IDLE, in_ready = 1, out_valid = 0, alu_result = 0, zero = 0, counter = 0. Assertion takes effect immediately, including mid-iteration; the in-flight op is lost.
- **After a flush or reset**, the first result comes only from a newly accepted operation.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 accepted at edge N → out_valid at N+1, alu_result 0x80000000, zero 0. SRA 0x80000000 by 0x00000024 (amount 4) → 0xF8000000.
- Branches: BEQ 5,5 → 0, zero 1. BLTU 1, 0xFFFFFFFF → 0, zero 1. BGEU 1, 0xFFFFFFFF → 1, zero 0. Undefined 0x1F → 0, zero 1.
- Multiply, with out_valid exactly at N+34:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Divide, with out_valid at N+34:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
  - DIV x / 0 → 0xFFFFFFFF; REMU 9 / 0 → 9.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Back-pressure and flush:
  - Hold out_ready low 5 cycles after a result → result and zero stable, in_ready 0. Raising out_ready → in_ready 1 on the next edge.
  - Flush 10 cycles into a DIV while in_valid is high → out_valid never rises, no op accepted that edge, in_ready 1 the following cycle.
- Reset: drop rst_n mid-MUL (no clock edge) → out_valid 0, alu_result 0, in_ready 1 immediately. After release, a new ADD 2+3 → 5 at accept+1.
